// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO controller slice.
//   out_state_t   : output-stage state (OUT_EMPTY / OUT_VALID)
//   ALMOST_MARGIN : headroom below DEPTH at which almost_full asserts
//   fifo_depth()  : entry count for a given bram address width
package fifo_pkg;

  localparam int ALMOST_MARGIN = 4;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping bram address pointer; used for both the write and the read side.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, clears the pointer
//   inc  : advance by one this cycle (DEPTH-1 wraps to 0)
//   ptr  : current pointer value
module fifo_ptr #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  // DEPTH is a power of two, so natural overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + ADDR_WIDTH'(1);
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/handshake controller turning a dual-port bram (1-cycle registered
// read) into a first-word-fall-through FIFO.
// Optional status outputs are enabled by defining FIFO_CTRL_STATUS_EN; without
// it level/almost_full/almost_empty are tied to 0.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   s_valid/s_ready/s_data        : upstream push handshake
//   m_valid/m_ready/m_data        : downstream pop handshake (m_data = bram_doutb)
//   bram_wea/bram_addra/bram_dina : bram write port
//   bram_enb/bram_addrb           : bram read port
//   bram_doutb                    : bram registered read data
//   level/almost_full/almost_empty: occupancy status
//
// Output FSM:
//   state     | meaning
//   OUT_EMPTY | no word on m_data, m_valid=0
//   OUT_VALID | bram_doutb holds the head word, m_valid=1
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [DATA_WIDTH-1:0] bram_dina,
  output logic                  bram_enb,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [DATA_WIDTH-1:0] bram_doutb,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW = ADDR_WIDTH + 1;

  out_state_t       state;
  logic [CW-1:0]    mem_cnt;
  logic [CW-1:0]    mem_cnt_nxt;
  logic             full;
  logic             s_fire;
  logic             rd_fire;

  // mem_cnt counts words still in the bram; the word on m_data is not included.
  assign full    = (mem_cnt == CW'(DEPTH));
  assign s_ready = ~full;
  assign s_fire  = s_valid & s_ready;
  // A read is issued only once the output slot is free or being vacated, and
  // only for words whose write edge has already happened (mem_cnt registered).
  assign rd_fire = (mem_cnt != '0) & (~m_valid | m_ready);

  assign bram_wea  = s_fire;
  assign bram_dina = s_data;
  assign bram_enb  = rd_fire;
  assign m_data    = bram_doutb;
  assign m_valid   = (state == OUT_VALID);

  always_comb begin
    mem_cnt_nxt = mem_cnt;
    case ({s_fire, rd_fire})
      2'b10:   mem_cnt_nxt = mem_cnt + CW'(1);
      2'b01:   mem_cnt_nxt = mem_cnt - CW'(1);
      default: mem_cnt_nxt = mem_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cnt <= '0;
      state   <= OUT_EMPTY;
    end else begin
      mem_cnt <= mem_cnt_nxt;
      case (state)
        OUT_EMPTY: if (rd_fire) state <= OUT_VALID;
        OUT_VALID: if (m_ready && !rd_fire) state <= OUT_EMPTY;
        default:   state <= OUT_EMPTY;
      endcase
    end
  end

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (s_fire),
    .ptr (bram_addra)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_fire),
    .ptr (bram_addrb)
  );

`ifdef FIFO_CTRL_STATUS_EN
  logic          m_valid_nxt;
  logic [CW-1:0] level_nxt;

  // Status is registered from next-cycle values so level equals the true
  // occupancy (bram words + output word) seen alongside m_valid/s_ready.
  assign m_valid_nxt = rd_fire | (m_valid & ~m_ready);
  assign level_nxt   = mem_cnt_nxt + CW'(m_valid_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      level        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b0;
    end else begin
      level        <= level_nxt;
      almost_full  <= (level_nxt >= CW'(DEPTH - ALMOST_MARGIN));
      almost_empty <= (level_nxt <= CW'(1));
    end
  end
`else
  assign level        = '0;
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

  localparam int AW    = 11;
  localparam int DW    = 15;
  localparam int DEPTH = 2048;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          bram_wea;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_dina;
  logic          bram_enb;
  logic [AW-1:0] bram_addrb;
  logic [DW-1:0] bram_doutb;
  logic [AW:0]   level;
  logic          almost_full;
  logic          almost_empty;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] wr_model;
  logic [AW-1:0] rd_model;
  logic [DW-1:0] mem [DEPTH];

  fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .bram_wea    (bram_wea),
    .bram_addra  (bram_addra),
    .bram_dina   (bram_dina),
    .bram_enb    (bram_enb),
    .bram_addrb  (bram_addrb),
    .bram_doutb  (bram_doutb),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural bram: write-first irrelevant, registered read, holds doutb when enb=0.
  always @(posedge clk) begin
    if (bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  // Scoreboard: mid-cycle sampling sees exactly what the next edge commits.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      wr_model = '0;
      rd_model = '0;
    end else begin
      if (bram_wea) begin
        n_cmp++;
        if (bram_addra !== wr_model || bram_dina !== s_data) begin
          n_bad++;
          $display("FAIL wr_port addra=%0d dina=%h want addra=%0d dina=%h", bram_addra, bram_dina, wr_model, s_data);
        end
        wr_model = wr_model + AW'(1);
      end
      if (bram_enb) begin
        n_cmp++;
        if (bram_addrb !== rd_model) begin
          n_bad++;
          $display("FAIL rd_addr addrb=%0d want %0d", bram_addrb, rd_model);
        end
        rd_model = rd_model + AW'(1);
      end
      if (m_valid && m_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pop_order got %h want <queue empty>", m_data);
        end else if (m_data !== exp_q[0]) begin
          n_bad++;
          $display("FAIL pop_order got %h want %h", m_data, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
    end
  end

  task automatic drive(input logic sv, input logic [DW-1:0] sd, input logic mr);
    @(posedge clk);
    #1;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || bram_wea !== 1'b0 || bram_enb !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs m_valid=%b s_ready=%b wea=%b enb=%b want 0 1 0 0", m_valid, s_ready, bram_wea, bram_enb);
    end
    n_cmp++;
    if (level !== '0 || almost_full !== 1'b0 || almost_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_status level=%0d af=%b ae=%b want 0 0 0", level, almost_full, almost_empty);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Empty FIFO with m_ready high: nothing issued, nothing presented.
    m_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0 || bram_enb !== 1'b0) begin
        n_bad++;
        $display("FAIL empty_pop m_valid=%b enb=%b want 0 0", m_valid, bram_enb);
      end
    end
  endtask

  task automatic test_single();
    drive(1'b1, 15'h0001, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bram_wea !== 1'b1 || bram_enb !== 1'b0 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_t0 wea=%b enb=%b m_valid=%b want 1 0 0", bram_wea, bram_enb, m_valid);
    end
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bram_enb !== 1'b1 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_t1 enb=%b m_valid=%b want 1 0", bram_enb, m_valid);
    end
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 15'h0001) begin
      n_bad++;
      $display("FAIL single_t2 m_valid=%b m_data=%h want 1 0001", m_valid, m_data);
    end
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_t3 m_valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_stream();
    int first = -1;
    int last  = -1;
    int pops  = 0;
    for (int c = 0; c < 110; c++) begin
      drive(c < 100, DW'(c), 1'b1);
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (first < 0) first = c;
        last = c;
        pops++;
      end
    end
    n_cmp++;
    if (pops !== 100 || first !== 2 || last !== 101) begin
      n_bad++;
      $display("FAIL stream pops=%0d first=%0d last=%0d want 100 2 101", pops, first, last);
    end
  endtask

  task automatic test_fill_drain();
    int acc = 0;
    int pops = 0;
    bit done = 0;
    for (int c = 0; c < 2200 && !done; c++) begin
      drive(1'b1, DW'(acc + 16'h100), 1'b0);
      @(negedge clk);
      if (s_ready) acc++;
      else done = 1;
    end
    // 2048 words sit in the bram plus one on the output register.
    n_cmp++;
    if (!done || acc !== DEPTH + 1) begin
      n_bad++;
      $display("FAIL fill_count accepted=%0d done=%0d want %0d", acc, done, DEPTH + 1);
    end
    n_cmp++;
    if (m_valid !== 1'b1 || bram_enb !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_hold m_valid=%b enb=%b want 1 0", m_valid, bram_enb);
    end
`ifdef FIFO_CTRL_STATUS_EN
    n_cmp++;
    if (level !== 12'(DEPTH + 1) || almost_full !== 1'b1 || almost_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_status level=%0d af=%b ae=%b want %0d 1 0", level, almost_full, almost_empty, DEPTH + 1);
    end
`else
    n_cmp++;
    if (level !== '0 || almost_full !== 1'b0 || almost_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL status_tied level=%0d af=%b ae=%b want 0 0 0", level, almost_full, almost_empty);
    end
`endif
    // Push and pop together while full: push still blocked this cycle.
    drive(1'b1, 15'h1234, 1'b1);
    @(negedge clk);
    if (m_valid && m_ready) pops++;
    n_cmp++;
    if (s_ready !== 1'b0 || bram_wea !== 1'b0) begin
      n_bad++;
      $display("FAIL full_pushpop s_ready=%b wea=%b want 0 0", s_ready, bram_wea);
    end
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    if (m_valid && m_ready) pops++;
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL full_release s_ready=%b want 1", s_ready);
    end
    done = 0;
    for (int c = 0; c < 2200 && !done; c++) begin
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      if (m_valid) pops++;
      else done = 1;
    end
    n_cmp++;
    if (!done || pops !== DEPTH + 1 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL drain pops=%0d done=%0d left=%0d want %0d 1 0", pops, done, exp_q.size(), DEPTH + 1);
    end
  endtask

  task automatic test_wrap_random();
    int pushed = 0;
    int pops = 0;
    bit done = 0;
    for (int c = 0; c < 20000 && !done; c++) begin
      drive(pushed < 3000, DW'(pushed * 7 + 3), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (s_valid && s_ready) pushed++;
      if (m_valid && m_ready) pops++;
      if (pushed == 3000 && exp_q.size() == 0 && !m_valid) done = 1;
    end
    n_cmp++;
    if (!done || pops !== 3000) begin
      n_bad++;
      $display("FAIL wrap_random pushed=%0d pops=%0d done=%0d want 3000 3000 1", pushed, pops, done);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 15'h0A0A, 1'b0);
    drive(1'b1, 15'h0B0B, 1'b0);
    drive(1'b1, 15'h0C0C, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 15'h0A0A || bram_enb !== 1'b0) begin
        n_bad++;
        $display("FAIL stall m_valid=%b m_data=%h enb=%b want 1 0a0a 0", m_valid, m_data, bram_enb);
      end
    end
    for (int c = 0; c < 8; c++) drive(1'b0, '0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL stall_drain m_valid=%b left=%0d want 0 0", m_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    for (int i = 0; i < 5; i++) drive(1'b1, DW'(16'h0500 + i), 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || level !== '0 || bram_enb !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid m_valid=%b s_ready=%b level=%0d enb=%b want 0 1 0 0", m_valid, s_ready, level, bram_enb);
    end
    drive(1'b1, 15'h7FFF, 1'b1);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (m_valid) begin
        seen = 1;
        n_cmp++;
        if (m_data !== 15'h7FFF) begin
          n_bad++;
          $display("FAIL reset_first_pop got %h want 7fff", m_data);
        end
      end
      drive(1'b0, '0, 1'b1);
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL reset_first_pop timeout m_valid=%b want 1", m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_fill_drain();
    test_wrap_random();
    test_stall();
    test_reset_mid();
    repeat (4) drive(1'b0, '0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
